// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised redirects and a circular
// return-address stack for call/return.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      STEP         = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned      RAS_DEPTH    = 8
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Halt,
  input  logic                           Branch,
  input  logic                           Zero,
  input  logic                           Jump,
  input  logic                           Call,
  input  logic                           Return,
  input  logic                           ChangePC,
  input  logic [WIDTH-1:0]               AddressJump,
  input  logic [WIDTH-1:0]               PcIn,
  output logic [WIDTH-1:0]               PcOut,
  output logic                           Taken,
  output logic [$clog2(RAS_DEPTH+1)-1:0] RasCount,
  output logic                           RasOverflow,
  output logic                           RasUnderflow
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int PTR_W = $clog2(RAS_DEPTH);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_INC,
    ACT_JUMP,
    ACT_CALL,
    ACT_RET,
    ACT_LOAD
  } action_t;

  action_t          action;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PTR_W-1:0] top, top_next, top_inc, top_dec;
  logic [CNT_W-1:0] cnt_next;
  logic [WIDTH-1:0] seq_pc, pc_next;
  logic             taken_next, ovf_next, unf_next, push_en;

  // top points at the next free slot; both directions wrap so a full stack
  // overwrites its oldest entry.
  assign seq_pc  = PcOut + WIDTH'(STEP);
  assign top_inc = (top == PTR_W'(RAS_DEPTH - 1)) ? '0 : top + PTR_W'(1);
  assign top_dec = (top == '0) ? PTR_W'(RAS_DEPTH - 1) : top - PTR_W'(1);

  always_comb begin
    action = ACT_HOLD;
    if (Branch && Zero) action = ACT_JUMP;
    else if (Jump)      action = ACT_JUMP;
    else if (Call)      action = ACT_CALL;
    else if (Return)    action = ACT_RET;
    else if (ChangePC)  action = ACT_LOAD;
    else if (!Halt)     action = ACT_INC;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    pc_next    = PcOut;
    top_next   = top;
    cnt_next   = RasCount;
    ovf_next   = RasOverflow;
    unf_next   = RasUnderflow;
    taken_next = 1'b0;
    push_en    = 1'b0;
    unique case (action)
      ACT_INC:  pc_next = seq_pc;
      ACT_JUMP: begin
        pc_next    = AddressJump;
        taken_next = 1'b1;
      end
      ACT_CALL: begin
        pc_next    = AddressJump;
        taken_next = 1'b1;
        push_en    = 1'b1;
        top_next   = top_inc;
        if (RasCount == CNT_W'(RAS_DEPTH)) ovf_next = 1'b1;
        else                               cnt_next = RasCount + CNT_W'(1);
      end
      ACT_RET: begin
        taken_next = 1'b1;
        if (RasCount == '0) begin
          pc_next  = AddressJump;
          unf_next = 1'b1;
        end else begin
          pc_next  = ras[top_dec];
          top_next = top_dec;
          cnt_next = RasCount - CNT_W'(1);
        end
      end
      ACT_LOAD: begin
        pc_next    = PcIn;
        taken_next = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      PcOut        <= RESET_VECTOR;
      Taken        <= 1'b0;
      RasCount     <= '0;
      RasOverflow  <= 1'b0;
      RasUnderflow <= 1'b0;
      top          <= '0;
    end else begin
      PcOut        <= pc_next;
      Taken        <= taken_next;
      RasCount     <= cnt_next;
      RasOverflow  <= ovf_next;
      RasUnderflow <= unf_next;
      top          <= top_next;
    end
  end

  // NOTE: stack storage has no reset; RasCount alone defines which entries
  // are valid, so clearing the array would only cost flops.
  always_ff @(posedge Clock) begin
    if (push_en && !Reset) ras[top] <= seq_pc;
  end

endmodule
